// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter from per-core L1 request ports onto a single registered
// coherence bus request slot. The slot holds its contents until the bus accepts
// them; a new winner may load in the same cycle the held request drains.

`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

package bus_rr_arbiter_pkg;
    localparam int unsigned ADDR_BITS      = `ADDR_BITS;
    localparam int unsigned OFFSET_BITS    = `OFFSET_BITS;
    localparam int unsigned CACHELINE_BITS = `CACHELINE_BITS;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2,
        BUS_WB   = 2'd3
    } bus_req_t;
endpackage

module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = ADDR_BITS - OFFSET_BITS,
    parameter int unsigned DATA_W  = CACHELINE_BITS,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   l1_req_valid,
    output logic [NUM_REQ-1:0]   l1_req_ready,
    input  logic [ADDR_W-1:0]    l1_req_addr [NUM_REQ],
    input  bus_req_t             l1_req      [NUM_REQ],
    input  logic [DATA_W-1:0]    l1_req_data [NUM_REQ],
    output logic                 bus_req_valid,
    input  logic                 bus_req_ready,
    output logic [ADDR_W-1:0]    bus_req_addr,
    output bus_req_t             bus_req,
    output logic [DATA_W-1:0]    bus_req_data,
    output logic [ID_W-1:0]      bus_req_cpu,
    output logic                 arb_busy
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   winner;
    logic              found;
    logic              can_load;
    logic              load;

    // Rotating priority search starting at rr_ptr_q; ID_W-bit add wraps since
    // NUM_REQ is a power of two.
    always_comb begin
        logic [ID_W-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'(rr_ptr_q + ID_W'(k));
            if (!found && l1_req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Grant gating: slot must be free or draining this cycle, never during reset.
    always_comb begin
        can_load     = reset_n && ((state_q == StEmpty) || bus_req_ready);
        load         = found && can_load;
        l1_req_ready = '0;
        if (load) begin
            l1_req_ready[winner] = 1'b1;
        end
    end

    // Slot occupancy next state; bus_req_ready is ignored while empty.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (load) state_d = StFull;
            StFull:  if (bus_req_ready && !load) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // Slot register, pointer and captured request; reset discards any held request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StEmpty;
            rr_ptr_q     <= '0;
            bus_req_addr <= '0;
            bus_req      <= BUS_RD;
            bus_req_data <= '0;
            bus_req_cpu  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                bus_req_addr <= l1_req_addr[winner];
                bus_req      <= l1_req[winner];
                bus_req_data <= l1_req_data[winner];
                bus_req_cpu  <= winner;
                rr_ptr_q     <= ID_W'(winner + 1'b1);
            end
        end
    end

    assign bus_req_valid = (state_q == StFull);
    assign arb_busy      = (state_q == StFull);

endmodule
